// File: rtl/dcache_types.sv
// Shared geometry, line type and controller state encoding for the direct-mapped data cache.
package dcache_types;
  localparam int S_OFFSET   = 5;
  localparam int S_INDEX    = 3;
  localparam int S_TAG      = 32 - S_OFFSET - S_INDEX;
  localparam int S_WORD     = S_OFFSET - 2;
  localparam int NUM_SETS   = 1 << S_INDEX;
  localparam int LINE_W     = 8 << S_OFFSET;
  localparam int LINE_BYTES = LINE_W / 8;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  // Word w of a line sits at bits [32w+31:32w].
  function automatic logic [31:0] line_word(input line_t line, input logic [S_WORD-1:0] word);
    return line[{word, 5'b00000} +: 32];
  endfunction
endpackage

// File: rtl/dcache_array.sv
// Flop-based register array: per-lane write enable, combinational read at the same index.
module dcache_array #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 8,
  parameter  int NUM_BE = 1,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int LANE_W = WIDTH / NUM_BE
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [IDX_W-1:0]  i_index,
  input  logic [NUM_BE-1:0] i_be,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_load) begin
      for (int b = 0; b < NUM_BE; b++) begin
        if (i_be[b]) r_mem[i_index][b*LANE_W +: LANE_W] <= i_wdata[b*LANE_W +: LANE_W];
      end
    end
  end

  assign o_rdata = r_mem[i_index];
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache between the CPU D-port and burst memory.
//   state     | meaning
//   IDLE      | waiting for mem_read/mem_write
//   COMPARE   | tag check; respond on hit, pick writeback or fill on miss
//   WRITEBACK | dirty victim line driven out on pmem_write
//   FILL      | requested line fetched on pmem_read
module dcache_responder
  import dcache_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [3:0]        mem_byte_enable,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp
);
  state_t              r_state;
  logic                r_mem_resp;
  logic [31:0]         r_mem_rdata;
  logic                r_pmem_read;
  logic                r_pmem_write;
  logic [31:0]         r_pmem_address;
  logic [LINE_W-1:0]   r_pmem_wdata;

  logic [31:0]         w_addr_line;
  logic [S_TAG-1:0]    w_addr_tag;
  logic [S_INDEX-1:0]  w_index;
  logic [S_WORD-1:0]   w_word;

  logic [LINE_W-1:0]   w_line_rd;
  logic [S_TAG-1:0]    w_tag_rd;
  logic                w_valid_rd;
  logic                w_dirty_rd;
  logic                w_hit;
  logic                w_victim_dirty;

  logic                w_fill_done;
  logic                w_wb_done;
  logic                w_wr_hit;
  logic                w_data_we;
  logic [LINE_BYTES-1:0] w_data_be;
  logic [LINE_W-1:0]   w_data_wdata;
  logic                w_dirty_we;

  // Masking keeps every address bit in use while forcing line alignment.
  assign w_addr_line = mem_address & ~((32'd1 << S_OFFSET) - 32'd1);
  assign w_addr_tag  = mem_address[31 -: S_TAG];
  assign w_index     = mem_address[S_OFFSET +: S_INDEX];
  assign w_word      = mem_address[2 +: S_WORD];

  assign w_hit          = w_valid_rd && (w_tag_rd == w_addr_tag);
  assign w_victim_dirty = w_valid_rd && w_dirty_rd;

  assign w_fill_done = (r_state == FILL) && pmem_resp;
  assign w_wb_done   = (r_state == WRITEBACK) && pmem_resp;
  assign w_wr_hit    = (r_state == COMPARE) && w_hit && mem_write;

  assign w_data_we  = w_fill_done || w_wr_hit;
  assign w_dirty_we = w_fill_done || w_wr_hit || w_wb_done;

  always_comb begin
    w_data_be    = '0;
    w_data_wdata = {(LINE_W/32){mem_wdata}};
    if (w_fill_done) begin
      w_data_be    = '1;
      w_data_wdata = pmem_rdata;
    end else begin
      w_data_be[{w_word, 2'b00} +: 4] = mem_byte_enable;
    end
  end

  dcache_array #(.WIDTH(LINE_W), .DEPTH(NUM_SETS), .NUM_BE(LINE_BYTES)) u_data (
    .clk     (clk),
    .i_rst_n (1'b1),
    .i_load  (w_data_we),
    .i_index (w_index),
    .i_be    (w_data_be),
    .i_wdata (w_data_wdata),
    .o_rdata (w_line_rd)
  );

  dcache_array #(.WIDTH(S_TAG), .DEPTH(NUM_SETS), .NUM_BE(1)) u_tag (
    .clk     (clk),
    .i_rst_n (rst),
    .i_load  (w_fill_done),
    .i_index (w_index),
    .i_be    (1'b1),
    .i_wdata (w_addr_tag),
    .o_rdata (w_tag_rd)
  );

  dcache_array #(.WIDTH(1), .DEPTH(NUM_SETS), .NUM_BE(1)) u_valid (
    .clk     (clk),
    .i_rst_n (rst),
    .i_load  (w_fill_done),
    .i_index (w_index),
    .i_be    (1'b1),
    .i_wdata (1'b1),
    .o_rdata (w_valid_rd)
  );

  dcache_array #(.WIDTH(1), .DEPTH(NUM_SETS), .NUM_BE(1)) u_dirty (
    .clk     (clk),
    .i_rst_n (rst),
    .i_load  (w_dirty_we),
    .i_index (w_index),
    .i_be    (1'b1),
    .i_wdata (w_wr_hit),
    .o_rdata (w_dirty_rd)
  );

  // Outputs are registered, so the hit decision for COMPARE is taken one edge early.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_mem_resp     <= 1'b0;
      r_mem_rdata    <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      r_mem_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_read || mem_write) begin
            r_state <= COMPARE;
            if (w_hit) begin
              r_mem_resp  <= 1'b1;
              r_mem_rdata <= line_word(w_line_rd, w_word);
            end
          end
        end
        COMPARE: begin
          if (w_hit) begin
            r_state <= IDLE;
          end else if (w_victim_dirty) begin
            r_state        <= WRITEBACK;
            r_pmem_write   <= 1'b1;
            r_pmem_address <= {w_tag_rd, w_index, {S_OFFSET{1'b0}}};
            r_pmem_wdata   <= w_line_rd;
          end else begin
            r_state        <= FILL;
            r_pmem_read    <= 1'b1;
            r_pmem_address <= w_addr_line;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            r_state        <= FILL;
            r_pmem_write   <= 1'b0;
            r_pmem_read    <= 1'b1;
            r_pmem_address <= w_addr_line;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            r_state     <= COMPARE;
            r_pmem_read <= 1'b0;
            r_mem_resp  <= 1'b1;
            r_mem_rdata <= line_word(pmem_rdata, w_word);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_resp     = r_mem_resp;
  assign mem_rdata    = r_mem_rdata;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench: CPU view checked against a flat memory, pmem traffic against set residency.
module tb_dcache_responder;
  logic         clk, rst;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address, mem_wdata, mem_rdata;
  logic [3:0]   mem_byte_enable;
  logic         mem_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata, pmem_wdata;

  dcache_responder u_dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0, errors = 0, cyc = 0, fill_done_cyc = 0;
  bit hold_mem = 1'b0, spur = 1'b0;

  typedef struct {bit wr; logic [31:0] addr; logic [255:0] data;} pm_ev_t;
  typedef struct {bit rd; logic [31:0] data;} exp_t;
  pm_ev_t pm_log[$];
  exp_t   exp_q[$];

  logic [31:0]  ref_mem [logic [31:0]];
  logic [255:0] bmem    [logic [31:0]];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [23:0]  m_tag   [8];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [255:0] bmem_get(input logic [31:0] a);
    logic [255:0] l;
    if (bmem.exists(a)) return bmem[a];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(a + 32'(4*w));
    return l;
  endfunction

  // Physical memory: random 0..3 cycle wait, optional stall, optional stray pmem_resp while idle.
  initial begin
    bit busy;
    int cnt;
    pm_ev_t ev;
    busy = 1'b0; cnt = 0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        pmem_resp = 1'b0; busy = 1'b0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0; busy = 1'b0;
      end else if (pmem_read || pmem_write) begin
        if (!busy) begin busy = 1'b1; cnt = $urandom_range(0, 3); end
        if (!hold_mem) begin
          if (cnt == 0) begin
            chk("pmem_align", {27'b0, pmem_address[4:0]}, 32'h0);
            ev.wr = pmem_write; ev.addr = pmem_address; ev.data = pmem_wdata;
            if (pmem_write) begin
              bmem[pmem_address] = pmem_wdata;
            end else begin
              pmem_rdata = bmem_get(pmem_address);
              ev.data = pmem_rdata;
              fill_done_cyc = cyc + 1;
            end
            pm_log.push_back(ev);
            pmem_resp = 1'b1;
          end else begin
            cnt--;
          end
        end
      end else begin
        busy = 1'b0;
        if (spur) begin pmem_resp = 1'b1; spur = 1'b0; end
      end
    end
  end

  // Monitor: every mem_resp consumes one scoreboard entry; loads compare data.
  always @(negedge clk) begin
    exp_t e;
    if (rst && mem_resp) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp actual=resp required=none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        if (e.rd) chk("rdata", mem_rdata, e.data);
      end
    end
  end

  task automatic cpu_access(input bit wr, input bit rd_too, input logic [31:0] addr,
                            input logic [3:0] mbe, input logic [31:0] wd, input bit keep,
                            output int resp_cyc);
    int issue_cyc, pm_before, n, exp_ev, n_ev;
    logic [2:0] idx;
    logic [23:0] tg;
    bit hit, wb;
    logic [31:0] wb_addr, old;
    exp_t e;
    idx = addr[7:5];
    tg  = addr[31:8];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    wb  = !hit && m_valid[idx] && m_dirty[idx];
    wb_addr = {m_tag[idx], idx, 5'b0};
    exp_ev = hit ? 0 : (wb ? 2 : 1);
    m_dirty[idx] = wr | (hit & m_dirty[idx]);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;

    @(posedge clk); #1;
    mem_read = !wr | rd_too; mem_write = wr;
    mem_address = addr; mem_byte_enable = mbe; mem_wdata = wd;
    issue_cyc = cyc;
    pm_before = pm_log.size();
    e.rd = !wr;
    e.data = ref_get(addr);
    if (wr) begin
      old = ref_get(addr);
      for (int b = 0; b < 4; b++) if (mbe[b]) old[8*b +: 8] = wd[8*b +: 8];
      ref_mem[addr] = old;
    end
    exp_q.push_back(e);

    n = 0;
    do begin @(negedge clk); n++; end while (!mem_resp && n < 300);
    resp_cyc = cyc;
    if (!mem_resp) begin
      checks++; errors++;
      $display("FAIL resp_timeout addr=%h actual=no_resp required=resp", addr);
      mem_read = 1'b0; mem_write = 1'b0;
    end else begin
      n_ev = pm_log.size() - pm_before;
      chk("pmem_events", 32'(n_ev), 32'(exp_ev));
      if (hit) begin
        chk("hit_latency", 32'(resp_cyc - issue_cyc), 32'd1);
      end else begin
        chk("fill_to_resp", 32'(resp_cyc), 32'(fill_done_cyc));
        if (n_ev == exp_ev) begin
          if (wb) begin
            chk("wb_is_write", {31'b0, pm_log[pm_before].wr}, 32'd1);
            chk("wb_addr", pm_log[pm_before].addr, wb_addr);
          end
          chk("fill_is_read", {31'b0, pm_log[pm_log.size()-1].wr}, 32'd0);
          chk("fill_addr", pm_log[pm_log.size()-1].addr, {addr[31:5], 5'b0});
        end
      end
      if (!keep) begin
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc, r0, r1, r2, r3, n;
    logic [255:0] l;
    logic [31:0] a;
    bit wr;
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
    mem_byte_enable = '0; mem_wdata = '0;
    for (int s = 0; s < 8; s++) begin m_valid[s] = 1'b0; m_dirty[s] = 1'b0; m_tag[s] = '0; end
    ref_mem[32'h0000_1004] = 32'hDEAD_BEEF;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_get(32'h0000_1000 + 32'(4*w));
    bmem[32'h0000_1000] = l;

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_resp",     {31'b0, mem_resp},   32'd0);
    chk("rst_pmem_read",    {31'b0, pmem_read},  32'd0);
    chk("rst_pmem_write",   {31'b0, pmem_write}, 32'd0);
    chk("rst_pmem_address", pmem_address,        32'd0);
    chk("rst_mem_rdata",    mem_rdata,           32'd0);
    chk("rst_pmem_wdata",   {31'b0, |pmem_wdata}, 32'd0);
    rst = 1'b1;

    cpu_access(1'b0, 1'b0, 32'h0000_1004, 4'h0, 32'h0, 1'b0, rc);
    cpu_access(1'b0, 1'b0, 32'h0000_1004, 4'h0, 32'h0, 1'b0, rc);
    cpu_access(1'b1, 1'b0, 32'h0000_1004, 4'b0110, 32'h1122_3344, 1'b0, rc);
    cpu_access(1'b0, 1'b0, 32'h0000_1004, 4'h0, 32'h0, 1'b0, rc);
    cpu_access(1'b0, 1'b0, 32'h0000_2004, 4'h0, 32'h0, 1'b0, rc);
    chk("wb_word1", pm_log[pm_log.size()-2].data[63:32], 32'hDE22_33EF);

    // Reset while a fill is outstanding; memory is stalled so it never answers.
    hold_mem = 1'b1;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h0000_3004;
    n = 0;
    do begin @(negedge clk); n++; end while (!pmem_read && n < 20);
    chk("midfill_pmem_read", {31'b0, pmem_read}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_drop_pmem_read",    {31'b0, pmem_read}, 32'd0);
    chk("rst_drop_mem_resp",     {31'b0, mem_resp},  32'd0);
    chk("rst_drop_pmem_address", pmem_address,       32'd0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hold_mem = 1'b0;
    for (int s = 0; s < 8; s++) begin m_valid[s] = 1'b0; m_dirty[s] = 1'b0; end
    cpu_access(1'b0, 1'b0, 32'h0000_2004, 4'h0, 32'h0, 1'b0, rc);

    // Request held high across four hits.
    cpu_access(1'b0, 1'b0, 32'h0000_2000, 4'h0, 32'h0, 1'b1, r0);
    cpu_access(1'b0, 1'b0, 32'h0000_2008, 4'h0, 32'h0, 1'b1, r1);
    cpu_access(1'b0, 1'b0, 32'h0000_2010, 4'h0, 32'h0, 1'b1, r2);
    cpu_access(1'b0, 1'b0, 32'h0000_201C, 4'h0, 32'h0, 1'b0, r3);
    chk("b2b_gap1", 32'(r1 - r0), 32'd2);
    chk("b2b_gap2", 32'(r2 - r1), 32'd2);
    chk("b2b_gap3", 32'(r3 - r2), 32'd2);

    for (int i = 0; i < 300; i++) begin
      a = 32'h0004_0000 + 32'($urandom_range(0, 3) << 8)
                        + 32'($urandom_range(0, 7) << 5)
                        + 32'($urandom_range(0, 7) << 2);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) spur = 1'b1;
      cpu_access(wr, wr && ($urandom_range(0, 3) == 0), a,
                 4'($urandom_range(0, 15)), $urandom, 1'b0, rc);
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the CPU D-port (data_read/data_write/address/mbe/wdata/rdata/resp) and the burst physical-memory port.
- Acts as the responder to the CPU's memory requests and as the initiator of 256-bit line fills and writebacks.

Parameters:
- S_OFFSET, 5, byte-offset bits per line (32-byte line, 8 words).
- S_INDEX, 3, index bits (8 sets); tag width = 32 - S_OFFSET - S_INDEX.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  CPU load request; held until mem_resp.
- mem_write  in  1  CPU store request; held until mem_resp.
- mem_address  in  32  word-aligned byte address (bits[1:0] = 0).
- mem_byte_enable  in  4  store byte mask; lane i writes wdata[8i+7:8i].
- mem_wdata  in  32  store data, already lane-aligned.
- mem_rdata  out  32  addressed word, valid while mem_resp = 1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line writeback request; held until pmem_resp.
- pmem_address  out  32  line-aligned address (bits[4:0] = 0).
- pmem_rdata  in  256  fill line, valid when pmem_resp = 1.
- pmem_wdata  out  256  writeback line.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state to IDLE; all valid and dirty bits cleared; tags cleared.
  - mem_resp, pmem_read, pmem_write = 0; mem_rdata, pmem_address, pmem_wdata = 0.
  - Data array is not reset.
- Reset mid-fill or mid-writeback: request dropped immediately; dirty data is lost (accepted).
- Arrays are flop-based with combinational read. Field split: tag = addr[31:8], index = addr[7:5], word = addr[4:2].
- IDLE:
  - mem_read | mem_write -> COMPARE; otherwise stay. No outputs asserted.
- COMPARE: hit = valid[index] && tag[index] == addr tag.
  - Hit, read: mem_resp = 1; mem_rdata = line[index].word[word]; next IDLE.
  - Hit, write: mem_resp = 1; enabled bytes merged into the word on this edge; dirty[index] set; next IDLE.
  - Miss, line clean or invalid: next FILL.
  - Miss, line valid and dirty: next WRITEBACK.
- WRITEBACK:
  - pmem_write = 1; pmem_address = {tag[index], index, 5'b0}; pmem_wdata = line[index].
  - On pmem_resp: clear dirty[index]; next FILL.
- FILL:
  - pmem_read = 1; pmem_address = {addr[31:5], 5'b0}.
  - On pmem_resp: load line from pmem_rdata; write tag; set valid; clear dirty; next COMPARE. The following cycle always hits.
- Latency:
  - Hit: request seen in IDLE at cycle 0, mem_resp at cycle 1.
  - Clean miss: 2 + fill wait + 1 cycles.
  - Dirty miss: adds the writeback wait.
- The CPU may keep the request asserted the cycle after mem_resp. IDLE treats this as a new request, so back-to-back hits complete every 2 cycles.
- mem_read and mem_write both high is illegal. Write takes priority.
- mem_byte_enable = 0 on a write: still a hit or allocate, with no bytes changed. The dirty bit is still set.
- pmem_resp outside WRITEBACK/FILL is ignored.
- Word offset in pmem_rdata/pmem_wdata: word w occupies bits [32w+31:32w].

Decomposition:
- Package dcache_types:
  - state enum {IDLE, COMPARE, WRITEBACK, FILL}.
  - S_OFFSET/S_INDEX defaults and derived S_TAG, NUM_SETS.
  - line typedef (logic [255:0]).
- One sub-module, dcache_array: parameterised width/depth register array with:
  - asynchronous active-low reset;
  - load, index, and per-byte write enable;
  - combinational read.
- Instance it for data (256-bit, 32 byte-enables), tag, valid, and dirty.

Test Plan:
- Reset, then read 0x0000_1004 with memory returning a line with word1 = 0xDEAD_BEEF -> pmem_read with pmem_address 0x0000_1000; mem_resp one cycle after the return; mem_rdata = 0xDEAD_BEEF.
- Repeat read 0x0000_1004 -> no pmem activity; mem_resp at cycle 1; rdata 0xDEAD_BEEF.
- Write 0x0000_1004, mbe 4'b0110, wdata 0x1122_3344 -> resp at cycle 1, no pmem activity; readback = 0xDE22_33EF.
- Read 0x0000_2004 (same index, new tag) -> pmem_write at 0x0000_1000 with word1 = 0xDE22_33EF first; then pmem_read at 0x0000_2000; then resp.
- Assert rst low while pmem_read is high -> pmem_read and mem_resp drop within the cycle. After release, read 0x0000_2004 misses again (valid cleared).
- Hold mem_read high across 4 consecutive hits -> mem_resp pulses on every second cycle with the correct words.
